// File: rtl/nn_pkg.sv
// Shared definitions for the accelerator datapath: default element width,
// standard pooling window sizes and helpers for sizing reduction trees.
package nn_pkg;

  localparam int DEFAULT_W = 8;
  localparam int POOL2X2   = 4;
  localparam int POOL3X3   = 9;

  // Number of entries on tree level lvl when reducing n leaves pairwise.
  function automatic int level_count(input int n, input int lvl);
    return (n + (1 << lvl) - 1) >> lvl;
  endfunction

  // Position of level lvl's first entry in a flat array that holds every level.
  function automatic int level_offset(input int n, input int lvl);
    int s;
    s = 0;
    for (int l = 0; l < lvl; l++) begin
      s += level_count(n, l);
    end
    return s;
  endfunction

endpackage

// File: rtl/max2_sel.sv
// Two-input compare-select node for a max/argmax tree.
// The left (a) pair wins on equality so that the lowest index survives.
module max2_sel
  import nn_pkg::*;
#(
  parameter int W      = DEFAULT_W,
  parameter bit SIGNED = 1'b0,
  parameter int IW     = 2
) (
  input  logic [W-1:0]  a_val,
  input  logic [IW-1:0] a_idx,
  input  logic [W-1:0]  b_val,
  input  logic [IW-1:0] b_idx,
  output logic [W-1:0]  val,
  output logic [IW-1:0] idx
);

  logic b_wins;

  generate
    if (SIGNED) begin : g_signed
      assign b_wins = $signed(b_val) > $signed(a_val);
    end else begin : g_unsigned
      assign b_wins = b_val > a_val;
    end
  endgenerate

  assign val = b_wins ? b_val : a_val;
  assign idx = b_wins ? b_idx : a_idx;

endmodule

// File: rtl/maxpool_window.sv
// Max/argmax over one pooling window per clock: balanced compare-select tree
// followed by a single output register stage.
module maxpool_window
  import nn_pkg::*;
#(
  parameter int N      = POOL2X2,
  parameter int W      = DEFAULT_W,
  parameter bit SIGNED = 1'b0,
  localparam int IW    = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [W-1:0]  data [0:N-1],
  output logic          out_valid,
  output logic [W-1:0]  out,
  output logic [IW-1:0] out_idx
);

  localparam int LEVELS = $clog2(N);
  localparam int TOTAL  = level_offset(N, LEVELS + 1);

  // All tree levels packed end to end; level 0 is the raw window, the last entry the root.
  logic [W-1:0]  node_val [TOTAL];
  logic [IW-1:0] node_idx [TOTAL];

  genvar gi, gl;

  generate
    for (gi = 0; gi < N; gi++) begin : g_leaf
      assign node_val[gi] = data[gi];
      assign node_idx[gi] = IW'(gi);
    end

    for (gl = 0; gl < LEVELS; gl++) begin : g_level
      localparam int SRC  = level_offset(N, gl);
      localparam int DST  = level_offset(N, gl + 1);
      localparam int SCNT = level_count(N, gl);
      localparam int DCNT = level_count(N, gl + 1);

      for (gi = 0; gi < DCNT; gi++) begin : g_node
        if (2 * gi + 1 < SCNT) begin : g_cmp
          max2_sel #(
            .W      (W),
            .SIGNED (SIGNED),
            .IW     (IW)
          ) u_max2 (
            .a_val (node_val[SRC + 2*gi]),
            .a_idx (node_idx[SRC + 2*gi]),
            .b_val (node_val[SRC + 2*gi + 1]),
            .b_idx (node_idx[SRC + 2*gi + 1]),
            .val   (node_val[DST + gi]),
            .idx   (node_idx[DST + gi])
          );
        end else begin : g_pass
          // Unpaired entry of an odd-sized level goes straight up.
          assign node_val[DST + gi] = node_val[SRC + 2*gi];
          assign node_idx[DST + gi] = node_idx[SRC + 2*gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_idx   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out     <= node_val[TOTAL-1];
        out_idx <= node_idx[TOTAL-1];
      end
    end
  end

endmodule

// File: tb/tb_maxpool_window.sv
// Self-checking bench for maxpool_window: 2x2 unsigned, 2x2 signed and 3x3
// unsigned instances driven in lockstep and checked against a max/argmax model.
module tb_maxpool_window;

  typedef logic [7:0] win_t [0:8];
  typedef struct packed {
    logic [7:0] val;
    logic [3:0] idx;
  } res_t;
  typedef struct {
    win_t       d;
    int         cfg;   // 0: 2x2 unsigned, 1: 2x2 signed, 2: 3x3 unsigned
    logic [7:0] eo;
    int         ei;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid;
  logic [7:0] d4u [0:3];
  logic [7:0] d4s [0:3];
  logic [7:0] d9  [0:8];
  logic       ov4u, ov4s, ov9;
  logic [7:0] o4u, o4s, o9;
  logic [1:0] i4u, i4s;
  logic [3:0] i9;

  maxpool_window #(.N(4), .W(8), .SIGNED(1'b0)) u_4u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data(d4u),
    .out_valid(ov4u), .out(o4u), .out_idx(i4u));
  maxpool_window #(.N(4), .W(8), .SIGNED(1'b1)) u_4s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data(d4s),
    .out_valid(ov4s), .out(o4s), .out_idx(i4s));
  maxpool_window #(.N(9), .W(8), .SIGNED(1'b0)) u_9 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data(d9),
    .out_valid(ov9), .out(o9), .out_idx(i9));

  res_t       q4u[$], q4s[$], q9[$];
  logic [7:0] last4u, last4s, last9;
  int         passed = 0;
  int         total  = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  function automatic res_t model(input win_t w, input int n, input bit sgn);
    res_t r;
    int   best, v;
    r.val = w[0];
    r.idx = 4'd0;
    if (sgn) best = int'($signed(w[0]));
    else     best = int'({24'd0, w[0]});
    for (int i = 1; i < n; i++) begin
      if (sgn) v = int'($signed(w[i]));
      else     v = int'({24'd0, w[i]});
      if (v > best) begin
        best  = v;
        r.val = w[i];
        r.idx = 4'(i);
      end
    end
    return r;
  endfunction

  task automatic apply(input win_t w, input logic v);
    in_valid = v;
    for (int i = 0; i < 4; i++) begin
      d4u[i] = w[i];
      d4s[i] = w[i];
    end
    for (int i = 0; i < 9; i++) d9[i] = w[i];
    if (v && rst_n) begin
      q4u.push_back(model(w, 4, 1'b0));
      q4s.push_back(model(w, 4, 1'b1));
      q9.push_back(model(w, 9, 1'b0));
    end
  endtask

  task automatic check_one(input string nm, input logic v, input bit have, input res_t r,
                           input logic ov, input logic [7:0] o, input logic [3:0] oi,
                           input logic [7:0] last);
    if (v) begin
      chk({nm, " scoreboard"}, int'(have), 1);
      chk({nm, " out_valid"}, int'(ov), 1);
      chk({nm, " out"}, int'(o), int'(r.val));
      chk({nm, " out_idx"}, int'(oi), int'(r.idx));
    end else begin
      chk({nm, " idle out_valid"}, int'(ov), 0);
      chk({nm, " hold out"}, int'(o), int'(last));
    end
  endtask

  task automatic check_outputs(input logic v, input string tag);
    res_t r;
    bit   have;
    r = '0; have = (q4u.size() != 0);
    if (v && have) r = q4u.pop_front();
    check_one({tag, " 4u"}, v, have, r, ov4u, o4u, {2'b00, i4u}, last4u);
    if (v) last4u = r.val;
    r = '0; have = (q4s.size() != 0);
    if (v && have) r = q4s.pop_front();
    check_one({tag, " 4s"}, v, have, r, ov4s, o4s, {2'b00, i4s}, last4s);
    if (v) last4s = r.val;
    r = '0; have = (q9.size() != 0);
    if (v && have) r = q9.pop_front();
    check_one({tag, " 9u"}, v, have, r, ov9, o9, i9, last9);
    if (v) last9 = r.val;
  endtask

  // Inputs change just after a falling edge; outputs are read on the next falling edge.
  task automatic step(input win_t w, input logic v, input string tag);
    apply(w, v);
    @(posedge clk);
    @(negedge clk);
    check_outputs(v, tag);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, " 4u out_valid"}, int'(ov4u), 0);
    chk({tag, " 4u out"}, int'(o4u), 0);
    chk({tag, " 4u out_idx"}, int'(i4u), 0);
    chk({tag, " 4s out_valid"}, int'(ov4s), 0);
    chk({tag, " 9u out_valid"}, int'(ov9), 0);
    chk({tag, " 9u out"}, int'(o9), 0);
    chk({tag, " 9u out_idx"}, int'(i9), 0);
  endtask

  function automatic win_t rand_win();
    win_t w;
    for (int i = 0; i < 9; i++) w[i] = 8'($urandom_range(0, 255));
    return w;
  endfunction

  vec_t tbl [6];
  win_t w;

  initial begin
    tbl[0] = '{d: '{8'h7F, 8'hFF, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, cfg: 0, eo: 8'hFF, ei: 1};
    tbl[1] = '{d: '{8'h7F, 8'hFF, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, cfg: 1, eo: 8'h7F, ei: 0};
    tbl[2] = '{d: '{8'h05, 8'h90, 8'h11, 8'h90, 8'h00, 8'h90, 8'h01, 8'h02, 8'h03}, cfg: 2, eo: 8'h90, ei: 1};
    tbl[3] = '{d: '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hC8}, cfg: 2, eo: 8'hC8, ei: 8};
    tbl[4] = '{d: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, cfg: 2, eo: 8'h00, ei: 0};
    tbl[5] = '{d: '{8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, cfg: 1, eo: 8'h80, ei: 0};
    last4u = 8'h00; last4s = 8'h00; last9 = 8'h00;

    // Window presented throughout reset must be discarded.
    w = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rst_n = 1'b1;
    apply(w, 1'b0);
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_cleared($sformatf("reset c%0d", c));
    end
    rst_n = 1'b1;
    step(w, 1'b1, "post-reset");
    chk("post-reset 4u out", int'(o4u), 8'h40);
    chk("post-reset 4u out_idx", int'(i4u), 3);
    chk("post-reset 4u out_valid", int'(ov4u), 1);

    foreach (tbl[k]) begin
      step(tbl[k].d, 1'b1, $sformatf("vec%0d", k));
      case (tbl[k].cfg)
        0: begin
          chk($sformatf("vec%0d table out", k), int'(o4u), int'(tbl[k].eo));
          chk($sformatf("vec%0d table idx", k), int'(i4u), tbl[k].ei);
        end
        1: begin
          chk($sformatf("vec%0d table out", k), int'(o4s), int'(tbl[k].eo));
          chk($sformatf("vec%0d table idx", k), int'(i4s), tbl[k].ei);
        end
        default: begin
          chk($sformatf("vec%0d table out", k), int'(o9), int'(tbl[k].eo));
          chk($sformatf("vec%0d table idx", k), int'(i9), tbl[k].ei);
        end
      endcase
    end

    // Streaming: three back-to-back windows, then idle.
    w = '{8'h01, 8'h11, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    step(w, 1'b1, "stream0");
    chk("stream0 4u out", int'(o4u), 8'h11);
    w = '{8'h22, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    step(w, 1'b1, "stream1");
    chk("stream1 4u out", int'(o4u), 8'h22);
    w = '{8'h01, 8'h02, 8'h03, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    step(w, 1'b1, "stream2");
    chk("stream2 4u out", int'(o4u), 8'h33);
    step(rand_win(), 1'b0, "stream idle0");
    chk("stream idle 4u out", int'(o4u), 8'h33);
    step(rand_win(), 1'b0, "stream idle1");

    for (int it = 0; it < 500; it++) begin
      step(rand_win(), ($urandom_range(0, 4) != 0), $sformatf("rnd%0d", it));
      if (it == 250) begin
        // Asynchronous reset between clock edges while a window is in flight.
        apply(rand_win(), 1'b1);
        #2 rst_n = 1'b0;
        #1 check_cleared("async reset");
        q4u.delete(); q4s.delete(); q9.delete();
        last4u = 8'h00; last4s = 8'h00; last9 = 8'h00;
        @(posedge clk);
        @(negedge clk);
        check_cleared("in reset");
        rst_n = 1'b1;
        step(rand_win(), 1'b0, "after release");
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
